// File: rtl/perm_pkg.sv
// perm_pkg: shared encodings for the permute_stream block.
//   mode_e  - permutation selector carried on the 2-bit mode port
//   state_e - job sequencer states
//   max2    - helper for sizing the rotate-amount field
package perm_pkg;

  typedef enum logic [1:0] {
    MODE_TRANSPOSE = 2'd0,
    MODE_ROW_ROT   = 2'd1,
    MODE_COL_ROT   = 2'd2,
    MODE_BYPASS    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PERM = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lane_permute.sv
// lane_permute: purely combinational bit-matrix permutation of one line.
// A line is a ROWS x COLS bit matrix, bit k = COLS*r + c.
//   line   - input line
//   mode   - 0 transpose, 1 row rotate, 2 column rotate, 3 bypass
//   shift  - rotate amount, reduced modulo COLS (mode 1) or ROWS (mode 2)
//   result - permuted line
module lane_permute
  import perm_pkg::*;
#(
  parameter  int ROWS = 5,
  parameter  int COLS = 5,
  localparam int W    = ROWS * COLS,
  localparam int SW   = $clog2(max2(ROWS, COLS) + 1)
) (
  input  logic [W-1:0]  line,
  input  logic [1:0]    mode,
  input  logic [SW-1:0] shift,
  output logic [W-1:0]  result
);

  localparam int RRW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CRW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [RRW-1:0] row_sh_s;
  logic [CRW-1:0] col_sh_s;
  logic [W-1:0]   trans_s;
  logic [W-1:0]   row_rot_s;
  logic [W-1:0]   col_rot_s;

  // After reduction the amount always fits the candidate vector index.
  assign row_sh_s = RRW'(shift % SW'(COLS));
  assign col_sh_s = CRW'(shift % SW'(ROWS));

  // Each output bit selects among every possible rotation source, so all
  // selects are constant and the rotate amount only drives a small mux.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [COLS-1:0] row_cand_s;
      logic [ROWS-1:0] col_cand_s;
      for (genvar s = 0; s < COLS; s++) begin : g_rs
        assign row_cand_s[s] = line[COLS*r + ((c - s + COLS) % COLS)];
      end
      for (genvar s = 0; s < ROWS; s++) begin : g_cs
        assign col_cand_s[s] = line[COLS*((r + s) % ROWS) + c];
      end
      assign row_rot_s[COLS*r+c] = row_cand_s[row_sh_s];
      assign col_rot_s[COLS*r+c] = col_cand_s[col_sh_s];
      // A non-square matrix has no transpose of the same shape: pass through.
      if (ROWS == COLS) begin : g_tr
        assign trans_s[COLS*r+c] = line[COLS*c+r];
      end else begin : g_tr_bypass
        assign trans_s[COLS*r+c] = line[COLS*r+c];
      end
    end
  end

  // Select the permutation requested by mode.
  always_comb begin
    result = line;
    case (mode)
      MODE_TRANSPOSE: result = trans_s;
      MODE_ROW_ROT:   result = row_rot_s;
      MODE_COL_ROT:   result = col_rot_s;
      MODE_BYPASS:    result = line;
      default:        result = line;
    endcase
  end

endmodule

// File: rtl/permute_stream.sv
// permute_stream: accepts NUM_LINES lines per job, permutes each one and
// hands it downstream, one line in flight at a time.
//   clk, rst            - clock, asynchronous active-low reset
//   start, mode, shift  - job request and its parameters (taken in IDLE)
//   in_valid/in_data/in_ready    - input line handshake
//   out_valid/out_data/out_ready - output line handshake
//   out_idx             - index of the line currently on out_data
//   busy, done          - job in progress, end-of-job pulse
module permute_stream
  import perm_pkg::*;
#(
  parameter  int ROWS      = 5,
  parameter  int COLS      = 5,
  parameter  int NUM_LINES = 64,
  localparam int W         = ROWS * COLS,
  localparam int SW        = $clog2(max2(ROWS, COLS) + 1),
  localparam int CNT_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SW-1:0]    shift,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_LINES - 1);

  state_e           state_r;
  logic [1:0]       mode_r;
  logic [SW-1:0]    shift_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     line_r;
  logic [W-1:0]     out_data_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;
  logic [W-1:0]     perm_s;

  // Permutation always works on the captured line with the job's latched
  // parameters, so port changes mid-job cannot leak in.
  lane_permute #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_lane (
    .line   (line_r),
    .mode   (mode_r),
    .shift  (shift_r),
    .result (perm_s)
  );

  // Job sequencer; every handshake/status output is a register set on the
  // transition into the state where it must be asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_BYPASS;
      shift_r     <= '0;
      cnt_r       <= '0;
      line_r      <= '0;
      out_data_r  <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r     <= mode;
            shift_r    <= shift;
            cnt_r      <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            line_r     <= in_data;
            in_ready_r <= 1'b0;
            state_r    <= ST_PERM;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_PERM: begin
          out_data_r  <= perm_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (cnt_r == LAST_IDX) begin
              cnt_r   <= '0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              cnt_r      <= cnt_r + CNT_W'(1);
              in_ready_r <= 1'b1;
              state_r    <= ST_LOAD;
            end
          end else begin
            state_r <= ST_OUT;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_permute_stream.sv
// tb_permute_stream: directed-vector bench for permute_stream (5x5, 64 lines).
module tb_permute_stream;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [2:0]  shift;
  logic        in_valid;
  logic [24:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [24:0] out_data;
  logic        out_ready;
  logic [5:0]  out_idx;
  logic        busy;
  logic        done;

  int n_checks;
  int n_pass;
  int done_cnt;

  logic [24:0] vin  [0:7];
  logic [24:0] vexp [0:7];

  permute_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .shift     (shift),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [24:0] pat(input int i);
    logic [31:0] t;
    t = 32'(i + 1) * 32'h0001_2345;
    return t[24:0] ^ 25'h1ABCDEF;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"},  {7'd0, out_data},   32'd0);
    check({tag, "_out_idx"},   {26'd0, out_idx},   32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
  endtask

  // Push one line, then check latency, data, index and hold under stall.
  task automatic xfer(input logic [24:0] d, input logic [24:0] e, input int idx, input int stall);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", {31'd0, (t < 10)}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 25'h0;
    @(negedge clk);
    check("perm_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_data",  {7'd0, out_data},   {7'd0, e});
    check("out_idx",   {26'd0, out_idx},   32'(idx));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data",  {7'd0, out_data},   {7'd0, e});
      check("stall_idx",   {26'd0, out_idx},   32'(idx));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] m, input logic [2:0] s, input int nvec,
                         input int stall_line, input int abort_line);
    int d0;
    logic [24:0] d;
    logic [24:0] e;
    d0 = done_cnt;
    @(negedge clk);
    mode  = m;
    shift = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = m ^ 2'd1;
    shift = s + 3'd2;
    check("start_busy",     {31'd0, busy},     32'd1);
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 64; i++) begin
      if (i == abort_line) begin
        rst = 1'b0;
        #2;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        return;
      end
      if (i == 5) begin
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd0;
        shift = 3'd2;
        @(negedge clk);
        start = 1'b0;
      end
      if (i < nvec) begin
        d = vin[i];
        e = vexp[i];
      end else if (m == 2'd3) begin
        d = pat(i);
        e = pat(i);
      end else begin
        d = 25'h0;
        e = 25'h0;
      end
      xfer(d, e, i, (i == stall_line) ? 5 : 0);
    end
    @(negedge clk);
    check("done_pulse",      {31'd0, done},      32'd1);
    check("done_busy",       {31'd0, busy},      32'd1);
    check("done_out_valid",  {31'd0, out_valid}, 32'd0);
    check("done_idx_wrap",   {26'd0, out_idx},   32'd0);
    @(negedge clk);
    check("after_done",      {31'd0, done},      32'd0);
    check("after_busy",      {31'd0, busy},      32'd0);
    check("done_count",      32'(done_cnt),      32'(d0 + 1));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    done_cnt  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    shift     = 3'd0;
    in_valid  = 1'b0;
    in_data   = 25'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Transpose.
    vin[0] = 25'h0000002; vexp[0] = 25'h0000020;
    vin[1] = 25'h0000001; vexp[1] = 25'h0000001;
    vin[2] = 25'h0000020; vexp[2] = 25'h0000002;
    vin[3] = 25'h1000000; vexp[3] = 25'h1000000;
    vin[4] = 25'h0000080; vexp[4] = 25'h0000800;
    run_job(2'd0, 3'd0, 5, -1, -1);

    // Row rotate by 1.
    vin[0] = 25'h0000001; vexp[0] = 25'h0000002;
    vin[1] = 25'h0000010; vexp[1] = 25'h0000001;
    vin[2] = 25'h0000200; vexp[2] = 25'h0000020;
    run_job(2'd1, 3'd1, 3, -1, -1);

    // Row rotate by 6 reduces to 1.
    vin[0] = 25'h0000001; vexp[0] = 25'h0000002;
    vin[1] = 25'h0000010; vexp[1] = 25'h0000001;
    run_job(2'd1, 3'd6, 2, -1, -1);

    // Row rotate by 5 reduces to 0, i.e. pass-through.
    vin[0] = 25'h1ABCDEF; vexp[0] = 25'h1ABCDEF;
    run_job(2'd1, 3'd5, 1, -1, -1);

    // Bypass full job with a stall on line 10 and a mid-job start.
    vin[0] = 25'h1ABCDEF; vexp[0] = 25'h1ABCDEF;
    run_job(2'd3, 3'd0, 1, 10, -1);

    // Column rotate by 1, abandoned by reset at line 30.
    vin[0] = 25'h0000020; vexp[0] = 25'h0000001;
    vin[1] = 25'h0000001; vexp[1] = 25'h0100000;
    run_job(2'd2, 3'd1, 2, -1, 30);

    // Restart after the abort must begin again at index 0.
    run_job(2'd2, 3'd1, 2, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/permute_stream.md
PERMUTE_STREAM -- requirements
Module: permute_stream

Interface
REQ-001 Parameter ROWS, default 5, number of rows in the bit matrix of one line.
REQ-002 Parameter COLS, default 5, number of columns; line width W = ROWS*COLS, bit index k = COLS*r + c.
REQ-003 Parameter NUM_LINES, default 64, number of lines processed per job; CNT_W = clog2(NUM_LINES), minimum 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-007 mode  input  2  0 transpose, 1 row-rotate, 2 column-rotate, 3 bypass; latched on accepted start.
REQ-008 shift  input  SW  rotate amount, SW = clog2(max(ROWS,COLS)+1); latched on accepted start.
REQ-009 in_valid / in_data[W-1:0] / in_ready  input/input/output  input line handshake.
REQ-010 out_valid / out_data[W-1:0] / out_ready  output/output/input  output line handshake.
REQ-011 out_idx  output  CNT_W  index (0..NUM_LINES-1) of the line on out_data.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle pulse after the last line is accepted downstream.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, PERM, OUT, DONE.
REQ-015 IDLE->LOAD on start; latch mode and shift; clear line counter.
REQ-016 LOAD: in_ready=1; on in_valid&&in_ready register in_data, go PERM.
REQ-017 PERM: one cycle; register permuted line into output register; go OUT.
REQ-018 OUT: out_valid=1; on out_ready increment counter; go DONE if counter was NUM_LINES-1, else LOAD.
REQ-019 DONE: done=1 for one cycle; go IDLE.
REQ-020 Latency: input acceptance to out_valid high is exactly 2 cycles; max throughput one line per 3 cycles.
REQ-021 out_data and out_idx SHALL remain stable while out_valid && !out_ready.
REQ-022 Mode 0: out(r,c) = in(c,r); if ROWS != COLS, mode 0 behaves as bypass.
REQ-023 Mode 1: out(r,c) = in(r, (c - shift) mod COLS), each row rotated toward higher c.
REQ-024 Mode 2: out(r,c) = in((r + shift) mod ROWS, c).
REQ-025 Mode 3: out_data = in_data.
REQ-026 shift SHALL be reduced modulo COLS (mode 1) or ROWS (mode 2); shift 0 equals bypass.
REQ-027 start outside IDLE SHALL be ignored; mode/shift changes mid-job SHALL have no effect.
REQ-028 in_ready SHALL be 0 outside LOAD; out_valid 0 outside OUT.
REQ-029 Counter SHALL wrap to 0 on entering DONE; out_idx equals counter during OUT.

Reset
REQ-030 On rst low: state IDLE, counter 0, line and output registers 0, latched mode 3, latched shift 0.
REQ-031 Reset outputs: in_ready 0, out_valid 0, out_data 0, out_idx 0, busy 0, done 0.
REQ-032 Reset mid-job SHALL abandon the job with no done pulse; next start begins at index 0.

Structure
REQ-033 Package perm_pkg SHALL hold the mode encodings and FSM state encodings.
REQ-034 Combinational sub-module lane_permute (parameters ROWS, COLS; ports line, mode, shift, result) SHALL implement REQ-022..026.

Verification
REQ-035 Mode 0, in_data 25'h0000002 -> out_data 25'h0000020 two cycles after acceptance, out_idx 0.
REQ-036 Mode 1, shift 1: 25'h0000001 -> 25'h0000002; 25'h0000010 -> 25'h0000001; shift 6 gives same as shift 1.
REQ-037 Mode 2, shift 1: 25'h0000020 -> 25'h0000001; mode 3: 25'h1ABCDEF -> 25'h1ABCDEF.
REQ-038 Full job of 64 lines, out_ready held low 5 cycles on line 10 -> out_data stable, out_idx 0..63 in order, one done pulse after line 63, busy low next cycle.
REQ-039 start pulsed mid-job and mode changed -> ignored; rst low at line 30 -> all outputs 0, no done; restart yields out_idx from 0.
